// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared types and constants for the divider issue controller
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } div_state_e;

  // One-hot bit positions inside req_op
  localparam int DIV_OP_DIV  = 0;
  localparam int DIV_OP_MOD  = 1;
  localparam int DIV_OP_DIVU = 2;
  localparam int DIV_OP_MODU = 3;

  localparam logic UNIT_SIGNED   = 1'b1;
  localparam logic UNIT_UNSIGNED = 1'b0;

endpackage

// File: rtl/div_axis_issue.sv
// rtl/div_axis_issue.sv - dividend/divisor stream issue with independent sent flags
module div_axis_issue (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic dvd_tready,
  input  logic dvs_tready,
  output logic dvd_tvalid,
  output logic dvs_tvalid,
  output logic all_sent
);

  logic sent_dvd_q, sent_dvd_d;
  logic sent_dvs_q, sent_dvs_d;
  logic dvd_fire, dvs_fire;

  // tvalid comes from flops only; it drops the cycle after the channel handshakes
  assign dvd_tvalid = active & !sent_dvd_q;
  assign dvs_tvalid = active & !sent_dvs_q;
  assign dvd_fire   = dvd_tvalid & dvd_tready;
  assign dvs_fire   = dvs_tvalid & dvs_tready;
  // Both channels done, counting a handshake happening this cycle
  assign all_sent   = (sent_dvd_q | dvd_fire) & (sent_dvs_q | dvs_fire);

  // Sent flags clear on a new request and accumulate handshakes otherwise
  always_comb begin
    sent_dvd_d = sent_dvd_q | dvd_fire;
    sent_dvs_d = sent_dvs_q | dvs_fire;
    if (start) begin
      sent_dvd_d = 1'b0;
      sent_dvs_d = 1'b0;
    end
  end

  // Sent flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_dvd_q <= 1'b0;
      sent_dvs_q <= 1'b0;
    end else begin
      sent_dvd_q <= sent_dvd_d;
      sent_dvs_q <= sent_dvs_d;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - sequences signed/unsigned divider cores for the EXE stage
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [3:0]         req_op,
  input  logic [WIDTH-1:0]   req_src1,
  input  logic [WIDTH-1:0]   req_src2,
  output logic               req_ready,
  input  logic               flush,
  output logic               res_valid,
  output logic [WIDTH-1:0]   res_data,
  input  logic               res_ack,
  output logic               s_dvd_tvalid,
  output logic               s_dvs_tvalid,
  input  logic               s_dvd_tready,
  input  logic               s_dvs_tready,
  output logic               u_dvd_tvalid,
  output logic               u_dvs_tvalid,
  input  logic               u_dvd_tready,
  input  logic               u_dvs_tready,
  output logic [WIDTH-1:0]   dvd_tdata,
  output logic [WIDTH-1:0]   dvs_tdata,
  input  logic               s_dout_tvalid,
  input  logic               u_dout_tvalid,
  input  logic [2*WIDTH-1:0] s_dout_tdata,
  input  logic [2*WIDTH-1:0] u_dout_tdata
);

  div_state_e       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             unit_q, unit_d;
  logic             kill_q, kill_d;

  logic               start, is_signed;
  logic               dvd_tready_sel, dvs_tready_sel;
  logic               dvd_tvalid, dvs_tvalid, all_sent;
  logic               dout_tvalid_sel;
  logic [2*WIDTH-1:0] dout_tdata_sel;
  logic [WIDTH-1:0]   res_sel;
  logic               stray_dout;

  assign is_signed       = (unit_q == UNIT_SIGNED);
  assign start           = (state_q == ST_IDLE) & req_valid & !flush;
  assign dvd_tready_sel  = is_signed ? s_dvd_tready  : u_dvd_tready;
  assign dvs_tready_sel  = is_signed ? s_dvs_tready  : u_dvs_tready;
  assign dout_tvalid_sel = is_signed ? s_dout_tvalid : u_dout_tvalid;
  assign dout_tdata_sel  = is_signed ? s_dout_tdata  : u_dout_tdata;

  div_axis_issue u_issue (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .active     (state_q == ST_ISSUE),
    .dvd_tready (dvd_tready_sel),
    .dvs_tready (dvs_tready_sel),
    .dvd_tvalid (dvd_tvalid),
    .dvs_tvalid (dvs_tvalid),
    .all_sent   (all_sent)
  );

  // The non-selected core never sees tvalid
  assign s_dvd_tvalid = dvd_tvalid & (unit_q == UNIT_SIGNED);
  assign s_dvs_tvalid = dvs_tvalid & (unit_q == UNIT_SIGNED);
  assign u_dvd_tvalid = dvd_tvalid & (unit_q == UNIT_UNSIGNED);
  assign u_dvs_tvalid = dvs_tvalid & (unit_q == UNIT_UNSIGNED);
  assign dvd_tdata    = src1_q;
  assign dvs_tdata    = src2_q;
  assign req_ready    = (state_q == ST_IDLE);
  assign res_valid    = (state_q == ST_DONE);
  assign res_data     = res_data_q;

  // Quotient for div/divu, remainder for mod/modu
  always_comb begin
    res_sel = '0;
    if (op_q[DIV_OP_DIV] | op_q[DIV_OP_DIVU])
      res_sel = dout_tdata_sel[2*WIDTH-1:WIDTH];
    else if (op_q[DIV_OP_MOD] | op_q[DIV_OP_MODU])
      res_sel = dout_tdata_sel[WIDTH-1:0];
  end

  // Request sequencing: accept, issue, wait, hold result, or drain a cancelled op
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    unit_d     = unit_q;
    kill_d     = kill_q;
    res_data_d = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = req_op;
          src1_d  = req_src1;
          src2_d  = req_src2;
          unit_d  = (req_op[DIV_OP_DIV] | req_op[DIV_OP_MOD]) ? UNIT_SIGNED : UNIT_UNSIGNED;
          kill_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush) kill_d = 1'b1;
        if (all_sent) state_d = (kill_q | flush) ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (dout_tvalid_sel) begin
          if (flush | kill_q) begin
            state_d = ST_IDLE;
          end else begin
            res_data_d = res_sel;
            state_d    = ST_DONE;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (res_ack | flush) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (dout_tvalid_sel) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      unit_q     <= UNIT_UNSIGNED;
      kill_q     <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      unit_q     <= unit_d;
      kill_q     <= kill_d;
      res_data_q <= res_data_d;
    end
  end

  // A core output outside WAIT/DRAIN, or from the other core, means the cores and controller disagree
  always_comb begin
    stray_dout = 1'b0;
    if ((state_q == ST_WAIT) || (state_q == ST_DRAIN))
      stray_dout = is_signed ? u_dout_tvalid : s_dout_tvalid;
    else
      stray_dout = s_dout_tvalid | u_dout_tvalid;
  end

  a_no_stray_dout: assert property (@(posedge clk) disable iff (reset) !stray_dout);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        req_ready;
  logic        flush;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ack;
  logic        s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid;
  logic        s_dvd_tready, s_dvs_tready, u_dvd_tready, u_dvs_tready;
  logic [31:0] dvd_tdata, dvs_tdata;
  logic        s_dout_tvalid, u_dout_tvalid;
  logic [63:0] s_dout_tdata, u_dout_tdata;
  logic [3:0]  tv;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign tv = {s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid};

  div_issue_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .req_ready(req_ready), .flush(flush),
    .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack),
    .s_dvd_tvalid(s_dvd_tvalid), .s_dvs_tvalid(s_dvs_tvalid),
    .s_dvd_tready(s_dvd_tready), .s_dvs_tready(s_dvs_tready),
    .u_dvd_tvalid(u_dvd_tvalid), .u_dvs_tvalid(u_dvs_tvalid),
    .u_dvd_tready(u_dvd_tready), .u_dvs_tready(u_dvs_tready),
    .dvd_tdata(dvd_tdata), .dvs_tdata(dvs_tdata),
    .s_dout_tvalid(s_dout_tvalid), .u_dout_tvalid(u_dout_tvalid),
    .s_dout_tdata(s_dout_tdata), .u_dout_tdata(u_dout_tdata)
  );

  // Advance one cycle; inputs set after this apply to the next edge, outputs read are post-edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current IDLE cycle; returns in cycle 1
  task automatic issue_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    total++; if (res_data !== 32'h0) begin bad++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
    total++; if (tv !== 4'b0000) begin bad++; $display("FAIL reset_tvalid got=%b exp=0000", tv); end
    total++; if ({dvd_tdata, dvs_tdata} !== 64'h0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", {dvd_tdata, dvs_tdata}); end
  endtask

  task automatic test_div_signed();
    issue_req(4'b0001, 32'hFFFF_FFF9, 32'd2);
    total++; if (tv !== 4'b1100) begin bad++; $display("FAIL div_tvalid_c1 got=%b exp=1100", tv); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL div_req_ready_c1 got=%b exp=0", req_ready); end
    total++; if (dvd_tdata !== 32'hFFFF_FFF9 || dvs_tdata !== 32'd2) begin bad++; $display("FAIL div_operands got=%h/%h exp=fffffff9/00000002", dvd_tdata, dvs_tdata); end
    for (int c = 2; c <= 6; c++) begin
      tick();
      total++; if (tv !== 4'b0000 || res_valid !== 1'b0) begin bad++; $display("FAIL div_wait_c%0d tvalid=%b res_valid=%b exp=0000/0", c, tv, res_valid); end
    end
    s_dout_tvalid = 1'b1;
    s_dout_tdata  = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tick();
    s_dout_tvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_result_hold%0d got=%b/%h exp=1/fffffffd", c, res_valid, res_data); end
      if (c == 2) res_ack = 1'b1;
      tick();
    end
    res_ack = 1'b0;
    total++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL div_after_ack got=%b/%b exp=0/1", res_valid, req_ready); end
  endtask

  task automatic test_modu_unsigned();
    issue_req(4'b1000, 32'd100, 32'd7);
    total++; if (tv !== 4'b0011) begin bad++; $display("FAIL modu_tvalid_c1 got=%b exp=0011", tv); end
    tick();
    total++; if (tv !== 4'b0000) begin bad++; $display("FAIL modu_tvalid_c2 got=%b exp=0000", tv); end
    u_dout_tvalid = 1'b1;
    u_dout_tdata  = {32'd14, 32'd2};
    tick();
    u_dout_tvalid = 1'b0;
    total++; if (res_valid !== 1'b1 || res_data !== 32'd2) begin bad++; $display("FAIL modu_result got=%b/%h exp=1/00000002", res_valid, res_data); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL modu_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_split_ready();
    s_dvd_tready = 1'b1;
    s_dvs_tready = 1'b0;
    issue_req(4'b0010, 32'd50, 32'd7);
    total++; if (tv !== 4'b1100) begin bad++; $display("FAIL split_c1 got=%b exp=1100", tv); end
    tick();
    s_dvd_tready = 1'b0;
    total++; if (tv !== 4'b0100) begin bad++; $display("FAIL split_c2 got=%b exp=0100", tv); end
    tick();
    total++; if (tv !== 4'b0100) begin bad++; $display("FAIL split_c3 got=%b exp=0100", tv); end
    s_dvs_tready = 1'b1;
    tick();
    total++; if (tv !== 4'b0000) begin bad++; $display("FAIL split_c4 got=%b exp=0000", tv); end
    s_dout_tvalid = 1'b1;
    s_dout_tdata  = {32'd7, 32'd1};
    tick();
    s_dout_tvalid = 1'b0;
    total++; if (res_valid !== 1'b1 || res_data !== 32'd1) begin bad++; $display("FAIL split_result got=%b/%h exp=1/00000001", res_valid, res_data); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    s_dvd_tready = 1'b1;
    s_dvs_tready = 1'b1;
  endtask

  task automatic test_flush_wait();
    issue_req(4'b0001, 32'd100, 32'd7);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      total++; if (res_valid !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL fwait_drain_c%0d got=%b/%b exp=0/0", c, res_valid, req_ready); end
      if (c == 5) begin
        s_dout_tvalid = 1'b1;
        s_dout_tdata  = {32'hDEAD_BEEF, 32'h1};
      end
      tick();
    end
    s_dout_tvalid = 1'b0;
    total++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL fwait_exit got=%b/%b exp=0/1", res_valid, req_ready); end
    issue_req(4'b0001, 32'd20, 32'd3);
    total++; if (tv !== 4'b1100) begin bad++; $display("FAIL fwait_next_tvalid got=%b exp=1100", tv); end
    tick();
    s_dout_tvalid = 1'b1;
    s_dout_tdata  = {32'd6, 32'd2};
    tick();
    s_dout_tvalid = 1'b0;
    total++; if (res_valid !== 1'b1 || res_data !== 32'd6) begin bad++; $display("FAIL fwait_next_result got=%b/%h exp=1/00000006", res_valid, res_data); end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  task automatic test_flush_issue();
    u_dvd_tready = 1'b0;
    u_dvs_tready = 1'b0;
    issue_req(4'b0100, 32'd9, 32'd2);
    flush = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      total++; if (tv !== 4'b0011 || req_ready !== 1'b0) begin bad++; $display("FAIL fissue_hold_c%0d got=%b/%b exp=0011/0", c, tv, req_ready); end
      if (c == 5) begin
        u_dvd_tready = 1'b1;
        u_dvs_tready = 1'b1;
      end
      tick();
      flush = 1'b0;
    end
    total++; if (tv !== 4'b0000 || req_ready !== 1'b0) begin bad++; $display("FAIL fissue_drain got=%b/%b exp=0000/0", tv, req_ready); end
    u_dout_tvalid = 1'b1;
    u_dout_tdata  = {32'd4, 32'd1};
    tick();
    u_dout_tvalid = 1'b0;
    total++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL fissue_exit got=%b/%b exp=0/1", res_valid, req_ready); end
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL fissue_no_result got=%b exp=0", res_valid); end
  endtask

  task automatic test_done_hold_flush_ack();
    issue_req(4'b0010, 32'hFFFF_FFF9, 32'd2);
    tick();
    s_dout_tvalid = 1'b1;
    s_dout_tdata  = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tick();
    s_dout_tvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++; if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL done_hold%0d got=%b/%h exp=1/ffffffff", c, res_valid, res_data); end
      tick();
    end
    flush   = 1'b1;
    res_ack = 1'b1;
    tick();
    flush   = 1'b0;
    res_ack = 1'b0;
    total++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL done_flush_ack got=%b/%b exp=0/1", res_valid, req_ready); end
  endtask

  task automatic test_reset_in_wait();
    issue_req(4'b0001, 32'd5, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL rwait_ctrl got=%b/%b exp=1/0", req_ready, res_valid); end
    total++; if (tv !== 4'b0000) begin bad++; $display("FAIL rwait_tvalid got=%b exp=0000", tv); end
    total++; if (res_data !== 32'h0 || dvd_tdata !== 32'h0 || dvs_tdata !== 32'h0) begin bad++; $display("FAIL rwait_data got=%h/%h/%h exp=0/0/0", res_data, dvd_tdata, dvs_tdata); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'b0; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; res_ack = 1'b0;
    s_dvd_tready = 1'b1; s_dvs_tready = 1'b1; u_dvd_tready = 1'b1; u_dvs_tready = 1'b1;
    s_dout_tvalid = 1'b0; u_dout_tvalid = 1'b0; s_dout_tdata = '0; u_dout_tdata = '0;
    #1;
    test_reset();
    test_div_signed();
    test_modu_unsigned();
    test_split_ready();
    test_flush_wait();
    test_flush_issue();
    test_done_hold_flush_ack();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
